// File: rtl/gpio_in_filt_if.sv
// gpio_in_filt_if: pad/config/result bundle for the GPIO input conditioning stage.
//   master : drives raw pad data and configuration, observes filtered data/events
//   slave  : the conditioning block
//   gpio_in_data             raw pads (async to mclk)
//   cfg_gpio_dir_sel         1 = output pin (events masked)
//   cfg_gpio_posedge_int_sel rising-edge event enable
//   cfg_gpio_negedge_int_sel falling-edge event enable
//   cfg_dbnc_div / _thr      debounce prescaler terminal count / tick threshold
//   gpio_filt_data           debounced levels
//   gpio_int_event           one-cycle edge events
//   dbnc_tick                prescaler tick
interface gpio_in_filt_if #(
   parameter int WD    = 32,
   parameter int DIV_W = 16
);
   logic [WD-1:0]    gpio_in_data;
   logic [WD-1:0]    cfg_gpio_dir_sel;
   logic [WD-1:0]    cfg_gpio_posedge_int_sel;
   logic [WD-1:0]    cfg_gpio_negedge_int_sel;
   logic [DIV_W-1:0] cfg_dbnc_div;
   logic [2:0]       cfg_dbnc_thr;
   logic [WD-1:0]    gpio_filt_data;
   logic [WD-1:0]    gpio_int_event;
   logic             dbnc_tick;

   modport master (
      output gpio_in_data, cfg_gpio_dir_sel, cfg_gpio_posedge_int_sel,
             cfg_gpio_negedge_int_sel, cfg_dbnc_div, cfg_dbnc_thr,
      input  gpio_filt_data, gpio_int_event, dbnc_tick
   );

   modport slave (
      input  gpio_in_data, cfg_gpio_dir_sel, cfg_gpio_posedge_int_sel,
             cfg_gpio_negedge_int_sel, cfg_dbnc_div, cfg_dbnc_thr,
      output gpio_filt_data, gpio_int_event, dbnc_tick
   );
endinterface

// File: rtl/gpio_in_filt.sv
// gpio_in_filt: double-synchronises WD raw GPIO pads to mclk, debounces each
// pin against a shared prescaler tick, and emits one-cycle edge events.
//   mclk     block clock
//   h_reset  asynchronous active-high reset
//   bus      gpio_in_filt_if.slave (pads, config, filtered data, events, tick)
// Optional feature: define GPIO_DBNC_EN to build the prescaler and per-pin
// stable counters. Without it the filter is transparent, dbnc_tick is 0 and
// cfg_dbnc_div / cfg_dbnc_thr are ignored.

// Per-pin slice: synchroniser, debounce filter, edge detector.
module gpio_in_filt_pin (
   input  logic       mclk,
   input  logic       h_reset,
   input  logic       pin_raw,
   input  logic       armed,
   input  logic       tick,
   input  logic [2:0] thr,
   input  logic       dir_sel,
   input  logic       pos_sel,
   input  logic       neg_sel,
   output logic       filt,
   output logic       evt
);
   logic sync1, sync2, filt_d, filt_nxt;
   logic rise, fall;

`ifdef GPIO_DBNC_EN
   logic [2:0] scnt, scnt_nxt;
   logic [3:0] scnt_inc;   // one bit wider so scnt==7 cannot wrap in the compare

   assign scnt_inc = {1'b0, scnt} + 4'd1;

   always_comb begin
      filt_nxt = filt;
      scnt_nxt = scnt;
      if (!armed || thr == 3'd0) begin
         filt_nxt = sync2;
         scnt_nxt = '0;
      end else if (sync2 == filt) begin
         scnt_nxt = '0;                 // glitch back restarts qualification
      end else if (tick) begin
         if (scnt_inc >= {1'b0, thr}) begin
            filt_nxt = sync2;
            scnt_nxt = '0;
         end else begin
            scnt_nxt = scnt_inc[2:0];
         end
      end
   end

   always_ff @(posedge mclk or posedge h_reset)
      if (h_reset) scnt <= '0;
      else         scnt <= scnt_nxt;
`else
   logic unused_dbnc;
   assign unused_dbnc = tick ^ (^thr);
   assign filt_nxt    = sync2;
`endif

   assign rise = filt & ~filt_d;
   assign fall = ~filt & filt_d;

   always_ff @(posedge mclk or posedge h_reset) begin
      if (h_reset) begin
         sync1  <= 1'b0;
         sync2  <= 1'b0;
         filt   <= 1'b0;
         filt_d <= 1'b0;
         evt    <= 1'b0;
      end else begin
         sync1  <= pin_raw;
         sync2  <= sync1;
         filt   <= filt_nxt;
         // While unarmed the delayed copy follows the same load as filt, so the
         // pad level picked up after reset never looks like an edge once armed.
         filt_d <= armed ? filt : filt_nxt;
         evt    <= armed & ((rise & pos_sel) | (fall & neg_sel)) & ~dir_sel;
      end
   end
endmodule

module gpio_in_filt #(
   parameter int WD    = 32,
   parameter int DIV_W = 16
) (
   input logic           mclk,
   input logic           h_reset,
   gpio_in_filt_if.slave bus
);
   typedef enum logic [1:0] {INIT0 = 2'd0, INIT1 = 2'd1, INIT2 = 2'd2, ARMED = 2'd3} arm_e;

   arm_e          arm_cnt;
   logic          armed;
   logic          tick;
   logic [2:0]    thr;
   logic [WD-1:0] filt_v, evt_v;

   // Arm sequencer: three bypass cycles after reset, then events enabled.
   always_ff @(posedge mclk or posedge h_reset) begin
      if (h_reset) begin
         arm_cnt <= INIT0;
         armed   <= 1'b0;
      end else begin
         case (arm_cnt)
            INIT0:   arm_cnt <= INIT1;
            INIT1:   arm_cnt <= INIT2;
            INIT2: begin
               arm_cnt <= ARMED;
               armed   <= 1'b1;
            end
            default: armed <= 1'b1;
         endcase
      end
   end

`ifdef GPIO_DBNC_EN
   logic [DIV_W-1:0] pcnt;

   // >= so that lowering the terminal count below pcnt wraps on the next cycle.
   // Gated by reset so the tick reads 0 while held in reset.
   assign tick = (pcnt >= bus.cfg_dbnc_div) & ~h_reset;
   assign thr  = bus.cfg_dbnc_thr;

   always_ff @(posedge mclk or posedge h_reset)
      if (h_reset)                     pcnt <= '0;
      else if (pcnt >= bus.cfg_dbnc_div) pcnt <= '0;
      else                             pcnt <= pcnt + DIV_W'(1);
`else
   logic unused_cfg;
   assign unused_cfg = (^bus.cfg_dbnc_div) ^ (^bus.cfg_dbnc_thr);
   assign tick       = 1'b0;
   assign thr        = 3'd0;
`endif

   for (genvar i = 0; i < WD; i++) begin : g_pin
      gpio_in_filt_pin u_pin (
         .mclk    (mclk),
         .h_reset (h_reset),
         .pin_raw (bus.gpio_in_data[i]),
         .armed   (armed),
         .tick    (tick),
         .thr     (thr),
         .dir_sel (bus.cfg_gpio_dir_sel[i]),
         .pos_sel (bus.cfg_gpio_posedge_int_sel[i]),
         .neg_sel (bus.cfg_gpio_negedge_int_sel[i]),
         .filt    (filt_v[i]),
         .evt     (evt_v[i])
      );
   end

   assign bus.gpio_filt_data = filt_v;
   assign bus.gpio_int_event = evt_v;
   assign bus.dbnc_tick      = tick;
endmodule

// File: tb/tb_gpio_in_filt.sv
// Directed bench for gpio_in_filt. Cycle index k counts negedges after reset
// release, so k samples the state left by posedge k.
module tb_gpio_in_filt;
   localparam int WD    = 32;
   localparam int DIV_W = 16;
`ifdef GPIO_DBNC_EN
   localparam bit DBNC = 1'b1;
`else
   localparam bit DBNC = 1'b0;
`endif

   logic mclk = 1'b0;
   logic h_reset;
   int   errors = 0;
   int   checks = 0;

   gpio_in_filt_if #(.WD(WD), .DIV_W(DIV_W)) bus ();

   gpio_in_filt #(.WD(WD), .DIV_W(DIV_W)) dut (
      .mclk    (mclk),
      .h_reset (h_reset),
      .bus     (bus)
   );

   always #5 mclk = ~mclk;

   task automatic setup(input logic [WD-1:0] dir, input logic [WD-1:0] pos,
                        input logic [WD-1:0] neg, input logic [DIV_W-1:0] div,
                        input logic [2:0] thr);
      bus.cfg_gpio_dir_sel         = dir;
      bus.cfg_gpio_posedge_int_sel = pos;
      bus.cfg_gpio_negedge_int_sel = neg;
      bus.cfg_dbnc_div             = div;
      bus.cfg_dbnc_thr             = thr;
   endtask

   task automatic do_reset();
      h_reset = 1'b1;
      repeat (2) @(negedge mclk);
      h_reset = 1'b0;
   endtask

   task automatic test_reset();
      int nev;
      nev = 0;
      bus.gpio_in_data = '0;
      setup('0, 32'h20, 32'h20, 16'd0, 3'd0);
      h_reset = 1'b1;
      bus.gpio_in_data[5] = 1'b1;
      repeat (2) @(negedge mclk);
      if (bus.gpio_filt_data !== '0) begin errors++; $display("FAIL rst_filt got=%h exp=0", bus.gpio_filt_data); end
      checks++;
      if (bus.gpio_int_event !== '0) begin errors++; $display("FAIL rst_evt got=%h exp=0", bus.gpio_int_event); end
      checks++;
      if (bus.dbnc_tick !== 1'b0) begin errors++; $display("FAIL rst_tick got=%b exp=0", bus.dbnc_tick); end
      checks++;
      h_reset = 1'b0;
      for (int k = 1; k <= 12; k++) begin
         @(negedge mclk);
         if (k == 3) begin
            if (bus.gpio_filt_data[5] !== 1'b1) begin errors++; $display("FAIL arm_filt5 got=%b exp=1", bus.gpio_filt_data[5]); end
            checks++;
         end
         nev += $countones(bus.gpio_int_event);
      end
      if (nev != 0) begin errors++; $display("FAIL arm_no_event got=%0d exp=0", nev); end
      checks++;
   endtask

   task automatic test_transparent_edge();
      logic exp_e;
      bus.gpio_in_data = '0;
      setup('0, 32'h1, '0, 16'd0, 3'd0);
      do_reset();
      for (int k = 1; k <= 12; k++) begin
         @(negedge mclk);
         if (k == 4) begin
            if (bus.dbnc_tick !== DBNC) begin errors++; $display("FAIL tick_div0 got=%b exp=%b", bus.dbnc_tick, DBNC); end
            checks++;
         end
         if (k == 7) begin
            if (bus.gpio_filt_data[0] !== 1'b0) begin errors++; $display("FAIL tr_filt_early got=%b exp=0", bus.gpio_filt_data[0]); end
            checks++;
         end
         if (k == 8) begin
            if (bus.gpio_filt_data[0] !== 1'b1) begin errors++; $display("FAIL tr_filt got=%b exp=1", bus.gpio_filt_data[0]); end
            checks++;
         end
         exp_e = (k == 9);
         if (bus.gpio_int_event[0] !== exp_e) begin errors++; $display("FAIL tr_evt k=%0d got=%b exp=%b", k, bus.gpio_int_event[0], exp_e); end
         checks++;
         if (k == 5) bus.gpio_in_data[0] = 1'b1;
      end
   endtask

   task automatic test_dir_edge(input bit outdir);
      int   nev;
      logic exp_e;
      nev = 0;
      bus.gpio_in_data = '0;
      setup(outdir ? 32'h8 : 32'h0, 32'h8, 32'h8, 16'd0, 3'd0);
      do_reset();
      for (int k = 1; k <= 20; k++) begin
         @(negedge mclk);
         if (k == 8) begin
            if (bus.gpio_filt_data[3] !== 1'b1) begin errors++; $display("FAIL dir%0d_filt_hi got=%b exp=1", outdir, bus.gpio_filt_data[3]); end
            checks++;
         end
         if (k == 13) begin
            if (bus.gpio_filt_data[3] !== 1'b0) begin errors++; $display("FAIL dir%0d_filt_lo got=%b exp=0", outdir, bus.gpio_filt_data[3]); end
            checks++;
         end
         exp_e = !outdir && (k == 9 || k == 14);
         if (bus.gpio_int_event[3] !== exp_e) begin errors++; $display("FAIL dir%0d_evt k=%0d got=%b exp=%b", outdir, k, bus.gpio_int_event[3], exp_e); end
         checks++;
         nev += $countones(bus.gpio_int_event);
         if (k == 5)  bus.gpio_in_data[3] = 1'b1;
         if (k == 10) bus.gpio_in_data[3] = 1'b0;
      end
      if (nev != (outdir ? 0 : 2)) begin errors++; $display("FAIL dir%0d_count got=%0d exp=%0d", outdir, nev, outdir ? 0 : 2); end
      checks++;
   endtask

`ifdef GPIO_DBNC_EN
   // div=3: tick visible when k%4==3; ticks consumed at posedges 16,20,24,28.
   task automatic test_dbnc_reject();
      logic exp_t;
      bus.gpio_in_data = '0;
      setup('0, 32'h80, 32'h80, 16'd3, 3'd4);
      do_reset();
      for (int k = 1; k <= 40; k++) begin
         @(negedge mclk);
         exp_t = (k % 4 == 3);
         if (bus.dbnc_tick !== exp_t) begin errors++; $display("FAIL rej_tick k=%0d got=%b exp=%b", k, bus.dbnc_tick, exp_t); end
         checks++;
         if (bus.gpio_filt_data[7] !== 1'b0) begin errors++; $display("FAIL rej_filt k=%0d got=%b exp=0", k, bus.gpio_filt_data[7]); end
         checks++;
         if (bus.gpio_int_event !== '0) begin errors++; $display("FAIL rej_evt k=%0d got=%h exp=0", k, bus.gpio_int_event); end
         checks++;
         if (k == 10) bus.gpio_in_data[7] = 1'b1;
         if (k == 22) bus.gpio_in_data[7] = 1'b0;
      end
   endtask

   task automatic test_dbnc_accept();
      logic exp_f, exp_e;
      bus.gpio_in_data = '0;
      setup('0, 32'h80, '0, 16'd3, 3'd4);
      do_reset();
      for (int k = 1; k <= 40; k++) begin
         @(negedge mclk);
         exp_f = (k >= 28);
         exp_e = (k == 29);
         if (bus.gpio_filt_data[7] !== exp_f) begin errors++; $display("FAIL acc_filt k=%0d got=%b exp=%b", k, bus.gpio_filt_data[7], exp_f); end
         checks++;
         if (bus.gpio_int_event[7] !== exp_e) begin errors++; $display("FAIL acc_evt k=%0d got=%b exp=%b", k, bus.gpio_int_event[7], exp_e); end
         checks++;
         if (k == 10) bus.gpio_in_data[7] = 1'b1;
      end
   endtask
`else
   task automatic test_dbnc_off();
      int nev;
      nev = 0;
      bus.gpio_in_data = '0;
      setup('0, 32'h80, 32'h80, 16'd3, 3'd4);
      do_reset();
      for (int k = 1; k <= 20; k++) begin
         @(negedge mclk);
         if (bus.dbnc_tick !== 1'b0) begin errors++; $display("FAIL off_tick k=%0d got=%b exp=0", k, bus.dbnc_tick); end
         checks++;
         if (k == 13) begin
            if (bus.gpio_filt_data[7] !== 1'b1) begin errors++; $display("FAIL off_filt got=%b exp=1", bus.gpio_filt_data[7]); end
            checks++;
         end
         nev += $countones(bus.gpio_int_event);
         if (k == 10) bus.gpio_in_data[7] = 1'b1;
         if (k == 12) bus.gpio_in_data[7] = 1'b0;
      end
      if (nev != 2) begin errors++; $display("FAIL off_count got=%0d exp=2", nev); end
      checks++;
   endtask
`endif

   task automatic test_reset_midqual();
      int nev;
      nev = 0;
      bus.gpio_in_data = '0;
      setup('0, 32'h80, 32'h80, 16'd3, 3'd7);
      do_reset();
      for (int k = 1; k <= 25; k++) begin
         @(negedge mclk);
         if (k == 10) bus.gpio_in_data[7] = 1'b1;
      end
      if (bus.gpio_filt_data[7] !== !DBNC) begin errors++; $display("FAIL mq_prefilt got=%b exp=%b", bus.gpio_filt_data[7], !DBNC); end
      checks++;
      h_reset = 1'b1;
      #1;
      if (bus.gpio_filt_data !== '0) begin errors++; $display("FAIL mq_rst_filt got=%h exp=0", bus.gpio_filt_data); end
      checks++;
      if (bus.gpio_int_event !== '0) begin errors++; $display("FAIL mq_rst_evt got=%h exp=0", bus.gpio_int_event); end
      checks++;
      if (bus.dbnc_tick !== 1'b0) begin errors++; $display("FAIL mq_rst_tick got=%b exp=0", bus.dbnc_tick); end
      checks++;
      @(negedge mclk);
      h_reset = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge mclk);
         if (k == 3) begin
            if (bus.gpio_filt_data[7] !== 1'b1) begin errors++; $display("FAIL mq_rearm_filt got=%b exp=1", bus.gpio_filt_data[7]); end
            checks++;
         end
         nev += $countones(bus.gpio_int_event);
      end
      if (nev != 0) begin errors++; $display("FAIL mq_rearm_evt got=%0d exp=0", nev); end
      checks++;
   endtask

   initial begin
      h_reset = 1'b1;
      bus.gpio_in_data = '0;
      setup('0, '0, '0, '0, 3'd0);
      test_reset();
      test_transparent_edge();
      test_dir_edge(1'b0);
      test_dir_edge(1'b1);
`ifdef GPIO_DBNC_EN
      test_dbnc_reject();
      test_dbnc_accept();
`else
      test_dbnc_off();
`endif
      test_reset_midqual();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
